// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter
// Debounces four active-low push buttons and turns each accepted press into
// an event offered through a valid/ready handshake. Presses that arrive
// together are served round-robin. A press landing on a button that already
// has an unserved event is merged into it, and that merge is flagged.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   btn_n[3:0]   raw asynchronous buttons, 0 = pressed
//   btn_level    debounced pressed level per button, 1 = pressed
//   evt_valid    a press event is offered
//   evt_id       index of the button whose press is offered
//   evt_ready    consumer accepts when evt_valid & evt_ready
//   evt_overrun  one-cycle pulse: a press was merged into a pending event
module btn_event_arbiter #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_n,
  output logic [3:0] btn_level,
  output logic       evt_valid,
  output logic [1:0] evt_id,
  input  logic       evt_ready,
  output logic       evt_overrun
);

  localparam int unsigned TICK_DIV = CLK_HZ / 1000;
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW       = $clog2(DEBOUNCE_MS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_MS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_e;

  logic [3:0]    sync1_q, sync2_q;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_s;
  logic [3:0]    s_q, s_d;
  logic [3:0]    s_dly_q;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    press_s;
  logic [3:0]    pend_q, pend_d;
  logic [3:0]    grant_mask_s;
  arb_state_e    state_q, state_d;
  logic [1:0]    evt_id_q, evt_id_d;
  logic [1:0]    last_q, last_d;
  logic          ovr_q, ovr_d;
  logic          hs_s, grant_s, found_s, hit_s;
  logic [1:0]    win_s, cand_s;

  // A press is the stable state going from released (1) to pressed (0),
  // seen one cycle after the stable state changes.
  assign press_s = s_dly_q & ~s_q;

  // Shared 1 ms prescaler.
  always_comb begin
    tick_s = (presc_q == PRESC_MAX);
    if (tick_s) begin
      presc_d = {PW{1'b0}};
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Per-button debounce: a mismatch must survive DEBOUNCE_MS ticks; any
  // cycle back at the stable value restarts the count.
  always_comb begin
    s_d = s_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == s_q[i]) begin
        cnt_d[i] = {CW{1'b0}};
      end else if (tick_s) begin
        if (cnt_q[i] == CNT_LAST) begin
          s_d[i]   = sync2_q[i];
          cnt_d[i] = {CW{1'b0}};
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Arbiter: round-robin winner search, pending bookkeeping, next state.
  always_comb begin
    hs_s    = (state_q == ST_OFFER) & evt_ready;
    grant_s = ((state_q == ST_IDLE) | hs_s) & (|pend_q);

    // Search starts just after the last winner; the last winner is checked last.
    win_s   = last_q;
    found_s = 1'b0;
    cand_s  = last_q;
    hit_s   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand_s  = last_q + 2'(k);
      hit_s   = ~found_s & pend_q[cand_s];
      win_s   = hit_s ? cand_s : win_s;
      found_s = found_s | hit_s;
    end

    grant_mask_s = grant_s ? (4'b0001 << win_s) : 4'b0000;
    // A press on the button being granted re-arms it instead of overrunning.
    pend_d = (pend_q & ~grant_mask_s) | press_s;
    ovr_d  = |(press_s & pend_q & ~grant_mask_s);

    if (grant_s) begin
      evt_id_d = win_s;
      last_d   = win_s;
    end else begin
      evt_id_d = evt_id_q;
      last_d   = last_q;
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          state_d = ST_OFFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (hs_s && !grant_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OFFER;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset clears everything immediately, dropping any offer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 4'hF;
      sync2_q  <= 4'hF;
      presc_q  <= {PW{1'b0}};
      s_q      <= 4'hF;
      s_dly_q  <= 4'hF;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= {CW{1'b0}};
      end
      pend_q   <= 4'h0;
      state_q  <= ST_IDLE;
      evt_id_q <= 2'd0;
      last_q   <= 2'd3;
      ovr_q    <= 1'b0;
    end else begin
      sync1_q  <= btn_n;
      sync2_q  <= sync1_q;
      presc_q  <= presc_d;
      s_q      <= s_d;
      s_dly_q  <= s_q;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pend_q   <= pend_d;
      state_q  <= state_d;
      evt_id_q <= evt_id_d;
      last_q   <= last_d;
      ovr_q    <= ovr_d;
    end
  end

  assign btn_level   = ~s_q;
  assign evt_valid   = (state_q == ST_OFFER);
  assign evt_id      = evt_id_q;
  assign evt_overrun = ovr_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Self-checking bench for btn_event_arbiter (CLK_HZ=10_000, DEBOUNCE_MS=4).
// A behavioural model predicts every grant; grants go into a queue that a
// monitor drains on each observed handshake.
module tb_btn_event_arbiter;

  localparam int CLK_HZ = 10_000;
  localparam int DB     = 4;
  localparam int TD     = CLK_HZ / 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_n = 4'hF;
  logic       evt_ready = 1'b0;
  logic [3:0] btn_level;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_overrun;

  btn_event_arbiter #(.CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .btn_level(btn_level),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_ready(evt_ready),
    .evt_overrun(evt_overrun)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int mcyc   = 0;

  // model state
  bit [3:0] m_sync1, m_sync2, m_s, m_sprev, m_pend;
  int       m_cnt [4];
  int       m_presc, m_id, m_last;
  bit       m_valid, m_ovr;
  int       exp_q [$];

  // observation logs for directed scenarios
  int hs_ids  [$];
  int hs_cycs [$];
  int ovr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, mcyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic void model_reset();
    m_sync1 = 4'hF; m_sync2 = 4'hF; m_s = 4'hF; m_sprev = 4'hF; m_pend = 4'h0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_presc = 0; m_id = 0; m_last = 3; m_valid = 1'b0; m_ovr = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_step();
    bit tick;
    bit [3:0] press;
    int granted;
    int idx;
    bit hs;
    bit ovr;
    tick    = (m_presc == TD - 1);
    m_presc = tick ? 0 : m_presc + 1;
    press   = m_sprev & ~m_s;
    m_sprev = m_s;
    for (int i = 0; i < 4; i++) begin
      if (m_sync2[i] == m_s[i]) m_cnt[i] = 0;
      else if (tick) begin
        m_cnt[i]++;
        if (m_cnt[i] == DB) begin
          m_s[i]   = m_sync2[i];
          m_cnt[i] = 0;
        end
      end
    end
    m_sync2 = m_sync1;
    m_sync1 = btn_n;
    hs      = m_valid && evt_ready;
    granted = -1;
    if (!m_valid || hs) begin
      for (int k = 1; k <= 4; k++) begin
        idx = (m_last + k) % 4;
        if (granted < 0 && m_pend[idx]) granted = idx;
      end
    end
    ovr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (press[i] && m_pend[i] && i != granted) ovr = 1'b1;
    end
    if (granted >= 0) begin
      m_pend[granted] = 1'b0;
      m_id    = granted;
      m_last  = granted;
      m_valid = 1'b1;
      exp_q.push_back(granted);
    end else if (hs) begin
      m_valid = 1'b0;
    end
    m_pend = m_pend | press;
    m_ovr  = ovr;
  endfunction

  // reference model, advanced on every clock edge, reset asynchronously
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // monitor: per-cycle output compare plus scoreboard pop on handshake
  initial begin
    bit [3:0] lvl_exp;
    int e;
    forever begin
      @(negedge clk);
      mcyc++;
      lvl_exp = ~m_s;
      check("valid", evt_valid, m_valid);
      check("overrun", evt_overrun, m_ovr);
      check("level", btn_level, lvl_exp);
      check("id", evt_id, m_id);
      if (evt_overrun === 1'b1) ovr_cnt++;
      if (rst_n && evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL hs_unexpected: got id %0d, expected no handshake", evt_id);
        end else begin
          e = exp_q.pop_front();
          check("hs_id", evt_id, e);
        end
        hs_ids.push_back(int'(evt_id));
        hs_cycs.push_back(mcyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    hs_ids.delete();
    hs_cycs.delete();
    ovr_cnt = 0;
  endtask

  task automatic wait_level(input int b, input logic val, input int maxc, output int n);
    n = 0;
    while (btn_level[b] !== val && n < maxc) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    int n;
    int nxt [4];
    step(3);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_id", evt_id, 2'd0);
    check("rst_overrun", evt_overrun, 1'b0);
    check("rst_level", btn_level, 4'h0);
    rst_n = 1'b1;
    step(5);

    // bounce on button 0, then held pressed
    evt_ready = 1'b1;
    clear_logs();
    for (int t = 0; t < 10; t++) begin
      btn_n[0] = ~btn_n[0];
      step(3);
    end
    btn_n[0] = 1'b0;
    wait_level(0, 1'b1, 100, n);
    check_range("bounce_window", n, 30, 42);
    step(10);
    check("bounce_events", hs_ids.size(), 1);
    if (hs_ids.size() > 0) check("bounce_id", hs_ids[0], 0);
    check("bounce_overrun", ovr_cnt, 0);

    // release only
    clear_logs();
    btn_n[0] = 1'b1;
    wait_level(0, 1'b0, 100, n);
    check_range("release_window", n, 30, 42);
    step(10);
    check("release_events", hs_ids.size(), 0);
    check("release_overrun", ovr_cnt, 0);

    // simultaneous press of buttons 1 and 3
    clear_logs();
    btn_n[1] = 1'b0;
    btn_n[3] = 1'b0;
    wait_level(1, 1'b1, 100, n);
    step(6);
    check("simul_events", hs_ids.size(), 2);
    if (hs_ids.size() == 2) begin
      check("simul_first", hs_ids[0], 1);
      check("simul_second", hs_ids[1], 3);
      check("simul_b2b", hs_cycs[1] - hs_cycs[0], 1);
    end
    check("simul_idle", evt_valid, 1'b0);
    btn_n = 4'hF;
    step(60);

    // backpressure on button 2
    evt_ready = 1'b0;
    clear_logs();
    repeat (3) begin
      btn_n[2] = 1'b0;
      step(50);
      btn_n[2] = 1'b1;
      step(50);
    end
    check("bp_overrun_pulses", ovr_cnt, 1);
    check("bp_valid", evt_valid, 1'b1);
    check("bp_id", evt_id, 2'd2);
    check("bp_no_hs", hs_ids.size(), 0);
    evt_ready = 1'b1;
    step(5);
    check("bp_events", hs_ids.size(), 2);
    if (hs_ids.size() == 2) begin
      check("bp_first", hs_ids[0], 2);
      check("bp_second", hs_ids[1], 2);
    end

    // fairness between buttons 0 and 1
    clear_logs();
    repeat (4) begin
      btn_n[1:0] = 2'b00;
      step(50);
      btn_n[1:0] = 2'b11;
      step(50);
    end
    check("fair_events", hs_ids.size(), 8);
    for (int j = 0; j < hs_ids.size(); j++) check("fair_order", hs_ids[j], j % 2);

    // reset during debounce and during an offer
    evt_ready = 1'b0;
    clear_logs();
    btn_n[0] = 1'b0;
    n = 0;
    while (evt_valid !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    check("pre_rst_offer", evt_valid, 1'b1);
    btn_n[3] = 1'b0;
    step(22);
    rst_n = 1'b0;
    btn_n[0] = 1'b1;
    #1;
    check("arst_valid", evt_valid, 1'b0);
    check("arst_id", evt_id, 2'd0);
    check("arst_level", btn_level, 4'h0);
    step(3);
    rst_n = 1'b1;
    clear_logs();
    evt_ready = 1'b1;
    wait_level(3, 1'b1, 100, n);
    check_range("post_rst_window", n, 38, 42);
    step(10);
    check("post_rst_events", hs_ids.size(), 1);
    if (hs_ids.size() > 0) check("post_rst_id", hs_ids[0], 3);
    btn_n = 4'hF;
    step(60);

    // randomized phase
    for (int i = 0; i < 4; i++) nxt[i] = $urandom_range(1, 40);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (c >= nxt[i]) begin
          btn_n[i] = ~btn_n[i];
          nxt[i] = c + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : $urandom_range(30, 90));
        end
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end

    // drain
    btn_n = 4'hF;
    evt_ready = 1'b1;
    step(100);
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", evt_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_event_arbiter.md
BTN_EVENT_ARBITER -- requirements
Module: btn_event_arbiter

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, is the clock frequency in Hz; the tick divider is TICK_DIV = CLK_HZ/1000.
REQ-002 Parameter DEBOUNCE_MS, default 20, is the number of 1 ms ticks an input change must persist to be accepted.
REQ-003 clk  input  1  system clock; all state SHALL be clocked on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 btn_n  input  4  raw asynchronous buttons, active-low (0 = pressed).
REQ-006 btn_level  output  4  debounced pressed level per button (1 = pressed).
REQ-007 evt_valid  output  1  a press event is offered.
REQ-008 evt_id  output  2  index of the button whose press is offered.
REQ-009 evt_ready  input  1  consumer accepts the event when evt_valid & evt_ready.
REQ-010 evt_overrun  output  1  one-cycle pulse: a press was coalesced into an already-pending event.

Function
REQ-011 Each btn_n bit SHALL pass through a 2-flop synchronizer; synchronizer flops reset to 1 (released).
REQ-012 A shared prescaler SHALL count 0..TICK_DIV-1 and assert tick for one cycle when it wraps from TICK_DIV-1 to 0.
REQ-013 Each button SHALL hold a stable state s[i] (reset 1) and a tick counter cnt[i] (reset 0) of width clog2(DEBOUNCE_MS+1).
REQ-014 In any cycle where the synchronized input equals s[i], cnt[i] SHALL clear to 0.
REQ-015 On a tick with a mismatch, cnt[i] SHALL increment; if cnt[i] == DEBOUNCE_MS-1, s[i] SHALL take the synchronized value and cnt[i] SHALL clear.
REQ-016 btn_level[i] SHALL equal ~s[i].
REQ-017 A 1->0 transition of s[i] SHALL set pending[i]. A 0->1 transition (release) SHALL generate no event.
REQ-018 If pending[i] is already 1 and is not being granted in that cycle when a new press is accepted, pending[i] SHALL stay 1 and evt_overrun SHALL pulse for one cycle.
REQ-019 If a press is accepted in the same cycle that button i is granted, pending[i] SHALL remain 1 and no overrun SHALL be flagged.
REQ-020 The arbiter SHALL have two states. IDLE (evt_valid=0) moves to OFFER when any pending bit is 1. OFFER (evt_valid=1) moves back to IDLE on a handshake when no further pending bit is 1; otherwise it stays in OFFER.
REQ-021 Grant SHALL occur when (state IDLE or handshake) and any pending bit is 1.
REQ-022 On grant, the winner SHALL be the first pending index found searching round-robin from last_grant+1 modulo 4.
REQ-023 On grant, evt_id SHALL take the winner's index, pending[winner] SHALL clear (subject to REQ-019), last_grant SHALL take the winner's index, and evt_valid SHALL be 1 the next cycle.
REQ-024 While evt_valid=1 and evt_ready=0, evt_id SHALL be held stable.
REQ-025 With evt_ready held high, back-to-back events SHALL be offered on consecutive cycles.
REQ-026 Latency from s[i] falling to evt_valid SHALL be 2 cycles when idle: 1 cycle to pending, 1 cycle to the output register.
REQ-027 evt_ready SHALL be ignored while evt_valid=0.

Reset
REQ-028 While rst_n=0, outputs SHALL be: evt_valid=0, evt_id=0, evt_overrun=0, btn_level=0.
REQ-029 While rst_n=0, internal state SHALL be: pending=0, s=4'hF, cnt=0, prescaler=0, last_grant=3, state IDLE.
REQ-030 Reset SHALL take effect immediately on assertion, including mid-debounce and mid-offer; an offered event is discarded.
REQ-031 Release of rst_n SHALL be followed by normal operation from the reset state on the next rising edge.

Verification (CLK_HZ=10_000 giving TICK_DIV=10, DEBOUNCE_MS=4)
REQ-032 Bounce: btn_n[0] toggles every 3 cycles for 30 cycles, then is held 0 -> btn_level[0] rises 30-42 cycles after the final edge; exactly one event with evt_id=0; evt_overrun stays 0.
REQ-033 Simultaneous press: btn 1 and btn 3 fall together, evt_ready=1 -> events evt_id=1 then evt_id=3 on consecutive cycles; then evt_valid=0.
REQ-034 Backpressure: evt_ready=0; btn 2 is pressed and released three times -> evt_id=2 is offered and stable throughout; the third press pulses evt_overrun once; after evt_ready=1, two handshakes with id 2 occur.
REQ-035 Fairness: btn 0 and btn 1 are re-pressed continuously, evt_ready=1 -> grants alternate 0,1,0,1 and neither is granted twice in a row while the other is pending.
REQ-036 Reset mid-operation: rst_n is pulsed low while btn_n[3]=0 is at cnt=2 and an event is offered -> outputs clear asynchronously; after release, btn_level[3] rises only after a full 4 stable ticks and exactly one event with evt_id=3 follows.
REQ-037 Release only: a held button is released -> btn_level clears after the debounce window; no event is generated and evt_overrun=0.
